// File: rtl/pll_lock_supervisor_pkg.sv
// Shared state encoding and timer sizing for the PLL lock supervisor.
package pll_supv_pkg;

   typedef enum logic [2:0] {
      PLL_RST   = 3'd0,
      WAIT_LOCK = 3'd1,
      STABLE    = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } supv_state_e;

   // FAULT backoff length in units of LOCK_TIMEOUT
   localparam int BACKOFF_MULT = 32'sd16;

   // One timer serves every phase, so size it for the longest interval
   function automatic int tmr_width(input int rst_cycles, input int lock_timeout,
                                    input int stable_cycles);
      int span;
      span = (rst_cycles > lock_timeout) ? rst_cycles : lock_timeout;
      span = (stable_cycles > span) ? stable_cycles : span;
      span = ((BACKOFF_MULT * lock_timeout) > span) ? (BACKOFF_MULT * lock_timeout) : span;
      return (span > 32'sd1) ? $clog2(span) : 32'sd1;
   endfunction

endpackage

// File: rtl/pll_lock_supervisor_rst_sync.sv
// Async-assert / sync-deassert reset synchroniser for one downstream clock domain.
module rst_sync
   import pll_supv_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic Clk,
   input  logic Rst,
   output logic sync_rst
);

   logic [SYNC_STAGES-1:0] chain_r;

   // Reset floods the chain with ones; zeros walk in on each domain edge
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         chain_r <= '1;
      end else begin
         chain_r <= {chain_r[SYNC_STAGES-2:0], 1'b0};
      end
   end

   assign sync_rst = chain_r[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor and reset sequencer. Define PLL_SUPV_AUTO_RECOVER_EN to let
// FAULT recover on its own after a backoff of 16 x LOCK_TIMEOUT cycles.
module pll_lock_supervisor
   import pll_supv_pkg::*;
#(
   parameter int N_DOMAINS     = 4,
   parameter int RST_CYCLES    = 20,
   parameter int LOCK_TIMEOUT  = 65535,
   parameter int STABLE_CYCLES = 1024,
   parameter int MAX_RETRY     = 7,
   parameter int SYNC_STAGES   = 2,
   parameter int CNT_W         = 8
) (
   input  logic                 Clk,
   input  logic                 Rst,
   input  logic                 pll_locked_i,
   input  logic                 retry_i,
   input  logic [N_DOMAINS-1:0] domain_clk_i,
   output logic                 pll_rst_o,
   output logic                 sys_rst_o,
   output logic [N_DOMAINS-1:0] domain_rst_o,
   output logic [2:0]           state_o,
   output logic                 fault_o,
   output logic [CNT_W-1:0]     lock_loss_cnt_o
);

   localparam int TMR_W = tmr_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
   localparam int RTY_W = $clog2(MAX_RETRY + 2);

   localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(RST_CYCLES - 1);
   localparam logic [TMR_W-1:0] TO_LAST     = TMR_W'(LOCK_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_MAX     = RTY_W'(MAX_RETRY);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;
`ifdef PLL_SUPV_AUTO_RECOVER_EN
   localparam logic [TMR_W-1:0] BACKOFF_LAST = TMR_W'(BACKOFF_MULT * LOCK_TIMEOUT - 1);
`endif

   logic [SYNC_STAGES-1:0] lk_sync_r;
   logic                   lk_s;
   supv_state_e            state_r, state_nxt_s;
   logic [TMR_W-1:0]       tmr_r, tmr_nxt_s;
   logic [RTY_W-1:0]       rty_r, rty_nxt_s;
   logic [CNT_W-1:0]       cnt_r, cnt_nxt_s;
   logic                   pll_rst_r, sys_rst_r, fault_r;
   logic                   dom_arst_s;

   // Bring the asynchronous lock flag into the Clk domain
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         lk_sync_r <= '0;
      end else begin
         lk_sync_r <= {lk_sync_r[SYNC_STAGES-2:0], pll_locked_i};
      end
   end

   assign lk_s = lk_sync_r[SYNC_STAGES-1];

   // Next-state, timer, retry and lock-loss bookkeeping
   always_comb begin
      state_nxt_s = state_r;
      tmr_nxt_s   = tmr_r;
      rty_nxt_s   = rty_r;
      cnt_nxt_s   = cnt_r;
      case (state_r)
         PLL_RST: begin
            if (tmr_r == RST_LAST) begin
               state_nxt_s = WAIT_LOCK;
               tmr_nxt_s   = '0;
            end else begin
               tmr_nxt_s = tmr_r + 1'b1;
            end
         end
         WAIT_LOCK: begin
            if (lk_s) begin
               state_nxt_s = STABLE;
               tmr_nxt_s   = '0;
            end else if (tmr_r == TO_LAST) begin
               // new count exceeds MAX_RETRY exactly when the old one already equals it
               rty_nxt_s   = rty_r + 1'b1;
               tmr_nxt_s   = '0;
               state_nxt_s = (rty_r >= RTY_MAX) ? FAULT : PLL_RST;
            end else begin
               tmr_nxt_s = tmr_r + 1'b1;
            end
         end
         STABLE: begin
            if (!lk_s) begin
               state_nxt_s = WAIT_LOCK;
               tmr_nxt_s   = '0;
            end else if (tmr_r == STABLE_LAST) begin
               state_nxt_s = RUN;
               tmr_nxt_s   = '0;
               rty_nxt_s   = '0;
            end else begin
               tmr_nxt_s = tmr_r + 1'b1;
            end
         end
         RUN: begin
            tmr_nxt_s = '0;
            if (!lk_s) begin
               state_nxt_s = PLL_RST;
               cnt_nxt_s   = (cnt_r == CNT_MAX) ? cnt_r : cnt_r + 1'b1;
            end else begin
               state_nxt_s = RUN;
            end
         end
         FAULT: begin
            if (retry_i) begin
               state_nxt_s = PLL_RST;
               tmr_nxt_s   = '0;
               rty_nxt_s   = '0;
            end else begin
`ifdef PLL_SUPV_AUTO_RECOVER_EN
               if (tmr_r == BACKOFF_LAST) begin
                  state_nxt_s = PLL_RST;
                  tmr_nxt_s   = '0;
                  rty_nxt_s   = '0;
               end else begin
                  tmr_nxt_s = tmr_r + 1'b1;
               end
`else
               tmr_nxt_s = '0;
`endif
            end
         end
         default: begin
            state_nxt_s = PLL_RST;
            tmr_nxt_s   = '0;
         end
      endcase
   end

   // State register; outputs decoded from the next state so they change with it
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         state_r   <= PLL_RST;
         tmr_r     <= '0;
         rty_r     <= '0;
         cnt_r     <= '0;
         pll_rst_r <= 1'b1;
         sys_rst_r <= 1'b1;
         fault_r   <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         tmr_r     <= tmr_nxt_s;
         rty_r     <= rty_nxt_s;
         cnt_r     <= cnt_nxt_s;
         pll_rst_r <= (state_nxt_s == PLL_RST) || (state_nxt_s == FAULT);
         sys_rst_r <= (state_nxt_s != RUN);
         fault_r   <= (state_nxt_s == FAULT);
      end
   end

   assign dom_arst_s = Rst | sys_rst_r;

   for (genvar g = 0; g < N_DOMAINS; g++) begin : g_dom
      rst_sync #(.SYNC_STAGES(SYNC_STAGES)) u_rst_sync (
         .Clk      (domain_clk_i[g]),
         .Rst      (dom_arst_s),
         .sync_rst (domain_rst_o[g])
      );
   end

   assign pll_rst_o       = pll_rst_r;
   assign sys_rst_o       = sys_rst_r;
   assign fault_o         = fault_r;
   assign state_o         = state_r;
   assign lock_loss_cnt_o = cnt_r;

endmodule
